// File: rtl/capq_pkg.sv
// Shared constants for the capture queue: mode encoding and overflow counter width.
package capq_pkg;

    // Value of the circ input selecting each queue mode.
    localparam logic CAPQ_FIFO = 1'b0;
    localparam logic CAPQ_CIRC = 1'b1;

    // Width of the optional overflow counter.
    localparam int CAPQ_OVF_W = 16;

endpackage

// File: rtl/capq_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// There is no reset, so the array maps onto block RAM. A read in the same
// cycle as a write to the same address returns the old contents.
module capq_ram #(
    parameter int DEPTH = 384,
    parameter int DW    = 16,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem [DEPTH];

    // Write port: store wdata when we is high.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: q loads on re and otherwise holds its last value.
    always_ff @(posedge clk) begin
        if (re) begin
            q <= mem[raddr];
        end
    end

endmodule

// File: rtl/capture_queue.sv
// Capture queue: NUM_CH side-by-side channels with FIFO or circular-overwrite mode.
// Optional feature: define CAPQ_OVERFLOW_CNT_EN to add the ovf_cnt output, a
// saturating count of dropped or overwritten samples.
//
// Read handshake: rd_en is the pop request. A pop is accepted when rd_en is high,
// the queue is not empty, and clr is low. For each accepted pop, rvalid is high
// on the following cycle with the popped entry on rdata. In all other cycles
// rvalid is low and rdata holds its last value.
module capture_queue
    import capq_pkg::*;
#(
    parameter  int ENTRIES = 384,
    parameter  int WIDTH   = 8,
    parameter  int NUM_CH  = 2,
    localparam int LOG2    = $clog2(ENTRIES),
    localparam int DW      = NUM_CH * WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            circ,
    input  logic            wr_en,
    input  logic [DW-1:0]   wdata,
    input  logic            rd_en,
    output logic [DW-1:0]   rdata,
    output logic            rvalid,
    output logic            full,
    output logic            empty,
    output logic [LOG2:0]   count
`ifdef CAPQ_OVERFLOW_CNT_EN
    ,
    output logic [CAPQ_OVF_W-1:0] ovf_cnt
`endif
);

    localparam logic [LOG2:0]   FULL_CNT = (LOG2 + 1)'(ENTRIES);
    localparam logic [LOG2-1:0] LAST_PTR = LOG2'(ENTRIES - 1);

    logic [LOG2-1:0] wr_ptr;
    logic [LOG2-1:0] rd_ptr;
    logic [LOG2:0]   count_q;
    logic            have_data;
    logic [DW-1:0]   ram_q;
    logic            rd_acc;
    logic            wr_acc;
    logic            rd_adv;
    logic            overwrite;

    // Advance a pointer by one, wrapping from the last entry to zero.
    function automatic logic [LOG2-1:0] ptr_inc(input logic [LOG2-1:0] p);
        return (p == LAST_PTR) ? '0 : p + LOG2'(1);
    endfunction

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;

    // Accept decisions use the flags as they were before the edge. clr blocks
    // every transfer.
    assign rd_acc    = !clr && rd_en && !empty;
    assign wr_acc    = !clr && wr_en && ((circ == CAPQ_CIRC) || !full || rd_acc);
    assign overwrite = !clr && wr_en && (circ == CAPQ_CIRC) && full && !rd_acc;
    assign rd_adv    = rd_acc || overwrite;

    // Before the first accepted pop the RAM output holds nothing meaningful,
    // so rdata is forced to zero until then.
    assign rdata = have_data ? ram_q : '0;

    // Pointers and occupancy count. An overwrite moves both pointers and
    // leaves the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_adv) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (wr_acc && !rd_adv) begin
                count_q <= count_q + (LOG2 + 1)'(1);
            end else if (!wr_acc && rd_acc) begin
                count_q <= count_q - (LOG2 + 1)'(1);
            end
        end
    end

    // rvalid pulses the cycle after each accepted pop. have_data records that
    // a real read has reached the RAM output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid    <= 1'b0;
            have_data <= 1'b0;
        end else begin
            rvalid <= rd_acc;
            if (rd_acc) begin
                have_data <= 1'b1;
            end
        end
    end

`ifdef CAPQ_OVERFLOW_CNT_EN
    logic drop;

    assign drop = !clr && wr_en && (circ == CAPQ_FIFO) && full && !rd_acc;

    // Saturating count of FIFO writes dropped and circular entries overwritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt <= '0;
        end else if (clr) begin
            ovf_cnt <= '0;
        end else if ((drop || overwrite) && (ovf_cnt != {CAPQ_OVF_W{1'b1}})) begin
            ovf_cnt <= ovf_cnt + CAPQ_OVF_W'(1);
        end
    end
`endif

    capq_ram #(
        .DEPTH (ENTRIES),
        .DW    (DW),
        .AW    (LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (wdata),
        .re    (rd_acc),
        .raddr (rd_ptr),
        .q     (ram_q)
    );

endmodule

// File: doc/capture_queue.md
CAPTURE_QUEUE -- requirements
Module: capture_queue

Interface
REQ-001 SHALL have parameter ENTRIES, default 384, meaning queue depth in samples; any value 2..4096 (power of two not required).
REQ-002 SHALL have parameter WIDTH, default 8, meaning bits per channel sample.
REQ-003 SHALL have parameter NUM_CH, default 2, meaning channels stored side by side at one shared address.
REQ-004 SHALL have localparam LOG2 = $clog2(ENTRIES), meaning pointer width.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning reset; asynchronous and active-high.
REQ-007 SHALL have port clr, input, 1, meaning synchronous flush.
REQ-008 SHALL have port circ, input, 1, meaning mode select: 0 = FIFO, 1 = circular overwrite.
REQ-009 SHALL have port wr_en, input, 1, meaning write request.
REQ-010 SHALL have port wdata, input, NUM_CH*WIDTH, meaning write data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-011 SHALL have port rd_en, input, 1, meaning pop request.
REQ-012 SHALL have port rdata, output, NUM_CH*WIDTH, meaning registered read data.
REQ-013 SHALL have port rvalid, output, 1, meaning rdata is fresh this cycle.
REQ-014 SHALL have ports full and empty, output, 1 each, meaning occupancy flags.
REQ-015 SHALL have port count, output, LOG2+1, meaning number of stored entries.

Function
REQ-016 SHALL keep registered wr_ptr and rd_ptr that advance by one and wrap from ENTRIES-1 to 0; no modulo subtraction; pointer never reaches ENTRIES.
REQ-017 SHALL sample full and empty from pre-edge state: full = (count == ENTRIES), empty = (count == 0).
REQ-018 SHALL accept a read when rd_en && !empty, then advance rd_ptr, and present the entry at the old rd_ptr on rdata with rvalid=1 exactly one cycle later.
REQ-019 SHALL hold rdata when no read is accepted and drive rvalid=0 that cycle.
REQ-020 SHALL in FIFO mode accept a write when wr_en && (!full || read accepted); otherwise drop it, with pointers and memory unchanged.
REQ-021 SHALL in circular mode always accept wr_en; when full with no read accepted, also advance rd_ptr (oldest discarded) and hold count at ENTRIES.
REQ-022 SHALL when full with read and write both accepted (either mode) advance each pointer by exactly one and leave count unchanged.
REQ-023 SHALL when empty with rd_en and wr_en both high reject the read, accept the write, and set count to 1.
REQ-024 SHALL when rd_ptr == wr_ptr on an accepted read and write in the same cycle return the old (pre-write) data.
REQ-025 SHALL treat circ as sampled per cycle; changing it mid-operation alters only subsequent write acceptance, never the stored data.
REQ-026 SHALL give clr priority over rd_en and wr_en: pointers and count go to 0, rvalid goes to 0, rdata is held, and memory is not cleared.

Reset
REQ-027 SHALL on rst asynchronously set wr_ptr, rd_ptr and count to 0, empty=1, full=0, rvalid=0, rdata=0, and leave memory contents undefined.
REQ-028 SHALL on rst asserted mid-operation lose all queued data and start cleanly on the first edge after deassertion.

Configuration
REQ-029 SHALL with CAPQ_OVERFLOW_CNT_EN defined add output ovf_cnt[15:0], which increments and saturates at 16'hFFFF on each dropped FIFO write or overwritten circular entry, and is zeroed by rst and clr.
REQ-030 SHALL without CAPQ_OVERFLOW_CNT_EN have no ovf_cnt port and no counter logic.

Structure
REQ-031 SHALL place the mode encoding constants (CAPQ_FIFO, CAPQ_CIRC) and the ovf_cnt width constant in shared package capq_pkg.
REQ-032 SHALL instantiate one sub-module, capq_ram: a simple dual-port RAM of ENTRIES x NUM_CH*WIDTH with a registered read, one write port and one read port, no reset, and synthesisable as block RAM.

Verification
REQ-033 SHALL reset, then in FIFO mode write 0x0100..0x0103 and pop 4 times -> rdata 0x0100..0x0103 each one cycle after its rd_en, then empty=1 and count=0.
REQ-034 SHALL in FIFO mode write 385 times -> full=1 after write 384, write 385 dropped, count=384, and ovf_cnt=1 when the macro is defined.
REQ-035 SHALL in circular mode write values 0..399 and then read 384 times -> first rdata=16, last rdata=399, and pointers wrap correctly through 383->0.
REQ-036 SHALL when full, assert rd_en and wr_en together for 10 cycles -> count stays 384 and the reads return the oldest 10 entries in order.
REQ-037 SHALL with count=5, assert clr and rd_en together -> count=0, empty=1, rvalid=0 next cycle, and a following pop is rejected.
REQ-038 SHALL assert rst asynchronously between edges with count=200 -> count=0, empty=1, rvalid=0 immediately, without waiting for a clock edge.
